// File: rtl/sd_data_pkg.sv
// Shared constants for the SD host data-path controller: state encoding,
// default widths and direction encoding.
package sd_data_pkg;

  localparam int unsigned BLK_W_DEF = 8;
  localparam int unsigned TO_W_DEF  = 16;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] WR_FIFO = 3'd2;
  localparam logic [2:0] TX      = 3'd3;
  localparam logic [2:0] RX      = 3'd4;
  localparam logic [2:0] RD_FIFO = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  localparam logic DIR_WRITE = 1'b1;
  localparam logic DIR_READ  = 1'b0;

  // States in which the per-block timeout runs
  function automatic logic is_wait_state(input logic [2:0] st);
    return (st == WR_FIFO) || (st == TX) || (st == RX) || (st == RD_FIFO);
  endfunction

endpackage

// File: rtl/sd_data_timeout_cnt.sv
// Saturating per-block timeout counter. `expired` compares the current count
// against the limit, so a limit of zero fires on the first counted cycle.
module sd_data_timeout_cnt #(
  parameter int unsigned TO_W = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and hold at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == limit);

endmodule

// File: rtl/sd_data_ctrl.sv
// SD host data-path controller: sequences single/multi-block write and read
// transfers through the FIFO handshake, with a per-block timeout.
// All outputs are registered decodes of the next state.
// Optional macro SD_DATA_ACK_HANDSHAKE_EN: DONE holds until Ack_in.
module sd_data_ctrl
  import sd_data_pkg::*;
#(
  parameter int unsigned BLK_W = BLK_W_DEF,
  parameter int unsigned TO_W  = TO_W_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             NewData,
  input  logic             WriteRead,
  input  logic [BLK_W-1:0] Blocks,
  input  logic             MultipleData,
  input  logic             Timeout_enable,
  input  logic [TO_W-1:0]  Timeout_reg,
  input  logic             Serial_ready,
  input  logic             Complete,
  input  logic             FIFO_ok,
  input  logic             Ack_in,
  output logic             Send,
  output logic             Direction,
  output logic             Idle,
  output logic             Data_transfer_complete,
  output logic             Timeout,
  output logic [BLK_W-1:0] Blocks_done
);

  logic [2:0]       state_q, state_d;
  logic             dir_q, dir_d;
  logic [BLK_W-1:0] blocks_q, blocks_d;
  logic             multi_q, multi_d;
  logic             to_en_q, to_en_d;
  logic [TO_W-1:0]  to_lim_q, to_lim_d;
  logic [BLK_W-1:0] bd_q, bd_d;
  logic             timeout_q, timeout_d;
  logic             send_q, send_d;
  logic             idle_q, idle_d;
  logic             dtc_q, dtc_d;

  logic [BLK_W-1:0] blk_tgt;
  logic [BLK_W-1:0] bd_inc;
  logic             expired;
  logic             to_fire;
  logic             cnt_clear;
  logic             cnt_enable;

`ifndef SD_DATA_ACK_HANDSHAKE_EN
  logic unused_ack_in;
  assign unused_ack_in = Ack_in;
`endif

  assign blk_tgt    = multi_q ? blocks_q : BLK_W'(1);
  assign bd_inc     = bd_q + BLK_W'(1);
  assign to_fire    = to_en_q && expired;
  // Every transition into a wait state is a state change, so this restarts the count
  assign cnt_clear  = (state_d != state_q);
  assign cnt_enable = to_en_q && is_wait_state(state_q);

  sd_data_timeout_cnt #(
    .TO_W (TO_W)
  ) u_timeout_cnt (
    .Clock   (Clock),
    .Reset   (Reset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .limit   (to_lim_q),
    .expired (expired)
  );

  // Next-state, latched configuration and Moore output decode
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    blocks_d  = blocks_q;
    multi_d   = multi_q;
    to_en_d   = to_en_q;
    to_lim_d  = to_lim_q;
    bd_d      = bd_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE: begin
        if (NewData && Serial_ready) begin
          state_d   = SETUP;
          dir_d     = WriteRead;
          blocks_d  = Blocks;
          multi_d   = MultipleData;
          to_en_d   = Timeout_enable;
          to_lim_d  = Timeout_reg;
          timeout_d = 1'b0;
          bd_d      = '0;
        end
      end
      SETUP: begin
        if (blk_tgt == '0) begin
          state_d = DONE;
        end else if (dir_q == DIR_WRITE) begin
          state_d = WR_FIFO;
        end else begin
          state_d = RX;
        end
      end
      WR_FIFO: begin
        if (FIFO_ok) begin
          state_d = TX;
        end else if (to_fire) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      TX: begin
        if (Complete) begin
          bd_d    = bd_inc;
          state_d = (bd_inc == blk_tgt) ? DONE : WR_FIFO;
        end else if (to_fire) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      RX: begin
        if (Complete) begin
          state_d = RD_FIFO;
        end else if (to_fire) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      RD_FIFO: begin
        if (FIFO_ok) begin
          bd_d    = bd_inc;
          state_d = (bd_inc == blk_tgt) ? DONE : RX;
        end else if (to_fire) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
`ifdef SD_DATA_ACK_HANDSHAKE_EN
        if (Ack_in) begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    send_d = (state_d == TX) || (state_d == RX);
    idle_d = (state_d == IDLE) || (state_d == DONE);
    dtc_d  = (state_d == DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      dir_q     <= DIR_READ;
      blocks_q  <= '0;
      multi_q   <= 1'b0;
      to_en_q   <= 1'b0;
      to_lim_q  <= '0;
      bd_q      <= '0;
      timeout_q <= 1'b0;
      send_q    <= 1'b0;
      idle_q    <= 1'b1;
      dtc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      blocks_q  <= blocks_d;
      multi_q   <= multi_d;
      to_en_q   <= to_en_d;
      to_lim_q  <= to_lim_d;
      bd_q      <= bd_d;
      timeout_q <= timeout_d;
      send_q    <= send_d;
      idle_q    <= idle_d;
      dtc_q     <= dtc_d;
    end
  end

  assign Send                   = send_q;
  assign Direction              = dir_q;
  assign Idle                   = idle_q;
  assign Data_transfer_complete = dtc_q;
  assign Timeout                = timeout_q;
  assign Blocks_done            = bd_q;

endmodule

// File: tb/tb_sd_data_ctrl.sv
// Directed self-checking bench for sd_data_ctrl. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
module tb_sd_data_ctrl;

  logic        Clock;
  logic        Reset;
  logic        NewData;
  logic        WriteRead;
  logic [7:0]  Blocks;
  logic        MultipleData;
  logic        Timeout_enable;
  logic [15:0] Timeout_reg;
  logic        Serial_ready;
  logic        Complete;
  logic        FIFO_ok;
  logic        Ack_in;
  logic        Send;
  logic        Direction;
  logic        Idle;
  logic        Data_transfer_complete;
  logic        Timeout;
  logic [7:0]  Blocks_done;

  int n_checks = 0;
  int n_fail   = 0;
  int send_hi  = 0;
  int dtc_hi   = 0;

`ifdef SD_DATA_ACK_HANDSHAKE_EN
  localparam int DoneCycles = 5;
`else
  localparam int DoneCycles = 1;
`endif

  sd_data_ctrl #(
    .BLK_W (8),
    .TO_W  (16)
  ) dut (
    .Clock                  (Clock),
    .Reset                  (Reset),
    .NewData                (NewData),
    .WriteRead              (WriteRead),
    .Blocks                 (Blocks),
    .MultipleData           (MultipleData),
    .Timeout_enable         (Timeout_enable),
    .Timeout_reg            (Timeout_reg),
    .Serial_ready           (Serial_ready),
    .Complete               (Complete),
    .FIFO_ok                (FIFO_ok),
    .Ack_in                 (Ack_in),
    .Send                   (Send),
    .Direction              (Direction),
    .Idle                   (Idle),
    .Data_transfer_complete (Data_transfer_complete),
    .Timeout                (Timeout),
    .Blocks_done            (Blocks_done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    if (Send) send_hi++;
    if (Data_transfer_complete) dtc_hi++;
  endtask

  // Issue an accepted start; returns sampled in SETUP. Inputs are then
  // scrambled to show the configuration was latched.
  task automatic start(input logic wr, input logic [7:0] blks, input logic multi,
                       input logic to_en, input logic [15:0] lim);
    WriteRead      = wr;
    Blocks         = blks;
    MultipleData   = multi;
    Timeout_enable = to_en;
    Timeout_reg    = lim;
    NewData        = 1'b1;
    Serial_ready   = 1'b1;
    step();
    NewData        = 1'b0;
    WriteRead      = ~wr;
    Blocks         = 8'hA5;
    MultipleData   = ~multi;
    Timeout_enable = ~to_en;
    Timeout_reg    = 16'h0002;
  endtask

  // Called while sampling the first DONE cycle; leaves the DUT in IDLE
  task automatic finish_done(input string tag);
    check_eq({tag, "_done_dtc"}, 32'(Data_transfer_complete), 32'd1);
    check_eq({tag, "_done_idle_send"}, {30'd0, Idle, Send}, 32'b10);
`ifdef SD_DATA_ACK_HANDSHAKE_EN
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq({tag, "_dtc_held"}, 32'(Data_transfer_complete), 32'd1);
    end
    Ack_in = 1'b1;
    step();
    Ack_in = 1'b0;
`else
    step();
`endif
    check_eq({tag, "_back_idle"}, {30'd0, Data_transfer_complete, Idle}, 32'b01);
  endtask

  initial begin
    int bad;
    Reset = 1'b1; NewData = 1'b0; WriteRead = 1'b0; Blocks = '0; MultipleData = 1'b0;
    Timeout_enable = 1'b0; Timeout_reg = '0; Serial_ready = 1'b0; Complete = 1'b0;
    FIFO_ok = 1'b0; Ack_in = 1'b0;
    step();
    step();
    check_eq("reset_outputs",
             {24'd0, Idle, Send, Direction, Data_transfer_complete, Timeout, 3'd0},
             {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
    check_eq("reset_blocks_done", 32'(Blocks_done), 32'd0);
    Reset = 1'b0;

    // NewData without Serial_ready is dropped, not queued
    NewData = 1'b1; WriteRead = 1'b1; Blocks = 8'd1;
    step();
    NewData = 1'b0; Serial_ready = 1'b1;
    step();
    step();
    check_eq("nodata_no_ready", {30'd0, Idle, Direction}, 32'b10);

    // Single write block, Send high exactly 5 cycles
    start(1'b1, 8'd1, 1'b0, 1'b0, 16'd0);
    check_eq("wr1_setup", {29'd0, Idle, Send, Direction}, 32'b001);
    step();
    step();
    send_hi = 0; dtc_hi = 0;
    FIFO_ok = 1'b1;
    step();
    FIFO_ok = 1'b0;
    repeat (4) step();
    Complete = 1'b1;
    step();
    Complete = 1'b0;
    check_eq("wr1_send_cycles", 32'(send_hi), 32'd5);
    check_eq("wr1_blocks_done", 32'(Blocks_done), 32'd1);
    check_eq("wr1_timeout", 32'(Timeout), 32'd0);
    finish_done("wr1");
    check_eq("wr1_dtc_cycles", 32'(dtc_hi), 32'(DoneCycles));

    // Three-block read; a NewData mid-transfer must be ignored
    start(1'b0, 8'd3, 1'b1, 1'b0, 16'd0);
    step();
    check_eq("rd3_rx_send", {30'd0, Send, Direction}, 32'b10);
    dtc_hi = 0;
    for (int b = 1; b <= 3; b++) begin
      if (b == 2) begin
        NewData = 1'b1; WriteRead = 1'b1;
      end
      step();
      NewData = 1'b0;
      Complete = 1'b1;
      step();
      Complete = 1'b0;
      check_eq("rd3_rdfifo_send", 32'(Send), 32'd0);
      step();
      FIFO_ok = 1'b1;
      step();
      FIFO_ok = 1'b0;
      check_eq("rd3_blocks_done", 32'(Blocks_done), 32'(b));
      if (b < 3) begin
        check_eq("rd3_mid", {29'd0, Data_transfer_complete, Send, Direction}, 32'b010);
      end
    end
    finish_done("rd3");
    check_eq("rd3_dtc_cycles", 32'(dtc_hi), 32'(DoneCycles));

    // Zero blocks in multi mode: SETUP then straight to DONE
    start(1'b1, 8'd0, 1'b1, 1'b0, 16'd0);
    check_eq("zero_setup_idle", 32'(Idle), 32'd0);
    step();
    check_eq("zero_blocks_done", 32'(Blocks_done), 32'd0);
    finish_done("zero");

    // Single-block mode ignores Blocks=5
    start(1'b1, 8'd5, 1'b0, 1'b0, 16'd0);
    step();
    FIFO_ok = 1'b1;
    step();
    FIFO_ok = 1'b0;
    Complete = 1'b1;
    step();
    Complete = 1'b0;
    check_eq("single5_blocks_done", 32'(Blocks_done), 32'd1);
    finish_done("single5");

    // Timeout of 70 in WR_FIFO: cycles 1..71 quiet, then DONE with Timeout
    start(1'b1, 8'd1, 1'b0, 1'b1, 16'd70);
    step();
    bad = 0;
    repeat (70) begin
      step();
      if (Timeout || Idle || Data_transfer_complete) bad++;
    end
    check_eq("to70_quiet", 32'(bad), 32'd0);
    step();
    check_eq("to70_timeout", 32'(Timeout), 32'd1);
    check_eq("to70_blocks_done", 32'(Blocks_done), 32'd0);
    finish_done("to70");
    check_eq("to70_sticky", 32'(Timeout), 32'd1);

    // Race: Complete coincides with counter == limit; Timeout cleared on accept
    start(1'b1, 8'd1, 1'b0, 1'b1, 16'd3);
    check_eq("race_timeout_cleared", 32'(Timeout), 32'd0);
    step();
    FIFO_ok = 1'b1;
    step();
    FIFO_ok = 1'b0;
    repeat (3) step();
    check_eq("race_still_tx", {30'd0, Send, Timeout}, 32'b10);
    Complete = 1'b1;
    step();
    Complete = 1'b0;
    check_eq("race_timeout", 32'(Timeout), 32'd0);
    check_eq("race_blocks_done", 32'(Blocks_done), 32'd1);
    finish_done("race");

    // Timeout_reg = 0 fires on the first wait-state cycle
    start(1'b0, 8'd2, 1'b1, 1'b1, 16'd0);
    step();
    check_eq("to0_rx_send", 32'(Send), 32'd1);
    step();
    check_eq("to0_timeout", {30'd0, Timeout, Send}, 32'b10);
    finish_done("to0");

    // Reset during TX of block 2 of 4
    start(1'b1, 8'd4, 1'b1, 1'b0, 16'd0);
    step();
    FIFO_ok = 1'b1;
    step();
    FIFO_ok = 1'b0;
    Complete = 1'b1;
    step();
    Complete = 1'b0;
    check_eq("rst_blk1_done", {23'd0, Blocks_done, Send}, {23'd0, 8'd1, 1'b0});
    FIFO_ok = 1'b1;
    step();
    FIFO_ok = 1'b0;
    step();
    check_eq("rst_in_tx2", 32'(Send), 32'd1);
    dtc_hi = 0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_eq("rst_outputs", {28'd0, Idle, Send, Data_transfer_complete, Direction}, 32'b1000);
    check_eq("rst_blocks_done", 32'(Blocks_done), 32'd0);
    repeat (3) step();
    check_eq("rst_no_dtc", 32'(dtc_hi), 32'd0);
    check_eq("rst_stays_idle", {30'd0, Idle, Send}, 32'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_data_ctrl.md
Name: sd_data_ctrl

Overview:
Synthesizable data-path controller for the SD host, generalising the current single-block DATA stimulus/handshake into a parametrised multi-block engine. It sits between the DMA/register bank and the physical (serial) layer, and sequences write and read block transfers through the FIFO handshake. It also runs a per-block programmable timeout and reports completion to the DMA.

Parameters:
BLK_W, 8, width of Blocks and of the block counter
TO_W, 16, width of Timeout_reg and of the timeout counter

Ports:
Clock  in  1  system clock; single clock domain
Reset  in  1  synchronous, active-high reset
NewData  in  1  start request, sampled only in IDLE
WriteRead  in  1  1 = write to card, 0 = read from card
Blocks  in  BLK_W  number of blocks to transfer
MultipleData  in  1  1 = multi-block; 0 = exactly one block regardless of Blocks
Timeout_enable  in  1  enables the per-block timeout
Timeout_reg  in  TO_W  timeout limit in Clock cycles
Serial_ready  in  1  physical layer ready to accept an operation
Complete  in  1  physical layer finished the current block (1-cycle pulse)
FIFO_ok  in  1  write: a block is available in the FIFO; read: the FIFO accepted the block
Ack_in  in  1  DMA acknowledge (used only with the optional feature)
Send  out  1  physical layer runs the current block (TX or RX)
Direction  out  1  latched WriteRead, forwarded to the physical layer
Idle  out  1  physical layer must stay in / return to idle
Data_transfer_complete  out  1  transfer finished, to DMA
Timeout  out  1  sticky timeout error flag
Blocks_done  out  BLK_W  number of blocks completed in the current transfer

Behaviour:
- Reset (synchronous): state=IDLE, Idle=1, Send=0, Direction=0, Data_transfer_complete=0, Timeout=0, Blocks_done=0, internal counters=0. Reset mid-transfer aborts immediately with no completion pulse.
- All outputs are registered (Moore decode of the next state). Each output changes one cycle after the causing input.
- IDLE: Idle=1.
  - NewData & Serial_ready -> SETUP. In the same cycle, latch WriteRead, Blocks, MultipleData, Timeout_enable, Timeout_reg; clear Timeout and Blocks_done.
  - NewData without Serial_ready is ignored, not queued.
- SETUP (1 cycle): Idle=0. Effective block count blk_tgt = MultipleData ? Blocks : 1.
  - blk_tgt==0 -> DONE.
  - Otherwise -> WR_FIFO if write, RX if read.
- WR_FIFO: wait for FIFO_ok -> TX.
- TX: Send=1 until Complete. On Complete, Blocks_done+1.
  - Blocks_done+1 == blk_tgt -> DONE.
  - Otherwise -> WR_FIFO.
- RX: Send=1 until Complete -> RD_FIFO.
- RD_FIFO: Send=0; wait for FIFO_ok. On FIFO_ok, Blocks_done+1.
  - Blocks_done+1 == blk_tgt -> DONE.
  - Otherwise -> RX.
- Timeout counter:
  - Cleared on entry to each wait state (WR_FIFO, TX, RX, RD_FIFO).
  - Increments every cycle in those states while the latched Timeout_enable=1.
  - Counter == Timeout_reg -> Timeout=1 (sticky until the next accepted NewData or Reset), state -> DONE.
  - Timeout_reg=0 with enable set fires on the first cycle of the wait state.
  - Counter saturates; it never wraps.
- Simultaneous events:
  - Complete or FIFO_ok in the same cycle as timeout expiry: the handshake wins, no Timeout.
  - NewData outside IDLE is ignored.
- Blocks_done wraps modulo 2^BLK_W; this is unreachable because blk_tgt ≤ 2^BLK_W−1.
- DONE: Data_transfer_complete=1, Send=0, Idle=1 for exactly 1 cycle -> IDLE.

Optional Feature:
SD_DATA_ACK_HANDSHAKE_EN
- Defined: DONE holds Data_transfer_complete=1 until Ack_in=1, then -> IDLE on the next edge.
  - Ack_in is ignored in all other states.
  - Reset still clears DONE.
- Undefined: DONE lasts 1 cycle and Ack_in is unused (left unconnected internally).

Decomposition:
- Package sd_data_pkg:
  - state encoding constants IDLE, SETUP, WR_FIFO, TX, RX, RD_FIFO, DONE (3-bit);
  - default BLK_W/TO_W values;
  - DIR_WRITE=1 and DIR_READ=0.
- One sub-module, sd_data_timeout_cnt:
  - parameter TO_W;
  - inputs clear, enable, limit;
  - output expired;
  - saturating counter.

Test Plan:
- Single write: Blocks=1, MultipleData=0, NewData & Serial_ready at t0; FIFO_ok at t0+3; Complete 5 cycles later -> Send high for exactly those cycles, Blocks_done=1, one-cycle Data_transfer_complete, Timeout=0.
- Multi-block read: Blocks=3, MultipleData=1, WriteRead=0 -> three RX/RD_FIFO pairs, Blocks_done steps 1,2,3, single completion pulse after the third FIFO_ok.
- MultipleData=0 with Blocks=5 -> exactly one block transferred, Blocks_done=1.
- Timeout: Timeout_enable=1, Timeout_reg=70, FIFO_ok never asserted -> Timeout=1 at the 71st WR_FIFO cycle, completion pulse, return to IDLE; Timeout clears on the next accepted NewData.
- Race: Complete coincides with counter==Timeout_reg -> block counted, Timeout stays 0. Also Blocks=0 with MultipleData=1 -> SETUP then DONE, Blocks_done=0.
- Reset asserted mid-TX of block 2 of 4 -> next cycle Idle=1, Send=0, Blocks_done=0, no completion pulse. With SD_DATA_ACK_HANDSHAKE_EN, Data_transfer_complete is held until Ack_in 4 cycles later.
